vdp_vram_arbiter: RTL and testbench

Shares the single VDP VRAM port between the background tile fetcher and the CPU data port. The fetcher keeps absolute priority and its fixed 8-cycle slot pattern is never disturbed. CPU writes are buffered in a small FIFO and retired in the fetcher's idle slots, or on any cycle during blanking. CPU reads are single-outstanding, ordered behind all earlier writes, and served in the same idle slots. It sits between the background fetcher, the VDP control/data-port logic and the VRAM macro.

---
 rtl/vdp_vram_arbiter.sv | 158 +++++++++++++++
 tb/tb_vdp_vram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_vram_arbiter.sv
// vdp_vram_arbiter
//   Shares the single VRAM port between the background tile fetcher and the
//   CPU data port. The fetcher always wins. CPU writes queue in a small FIFO
//   and CPU reads wait in a one-deep request FSM. Both are served only in
//   free cycles, which are blanking or fetcher phases 3 and 0. In phases 3
//   and 0 the fetcher drives a dummy address and ignores the read data.
//
// Ports
//   clk, rst_n        pixel clock; synchronous active-low reset
//   active            1 = active display
//   slot_phase        fetcher tile column for the current cycle
//   bg_vram_addr      fetcher address (combinational pass-through)
//   cpu_wr_*          write request/ready handshake into the FIFO
//   cpu_rd_*          single-outstanding read request, busy, valid pulse, data
//   vram_*            VRAM macro port; vram_rdata is valid in the same cycle
//
// Read FSM
//   state   | meaning
//   RD_IDLE | no read outstanding, a new request is accepted
//   RD_WAIT | address latched, waiting for a free cycle with the FIFO empty
//   RD_DONE | data captured, cpu_rd_valid pulses for this one cycle
module vdp_vram_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic [2:0]  slot_phase,
  input  logic [13:0] bg_vram_addr,
  input  logic        cpu_wr_valid,
  input  logic [13:0] cpu_wr_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_wr_ready,
  input  logic        cpu_rd_req,
  input  logic [13:0] cpu_rd_addr,
  output logic        cpu_rd_busy,
  output logic        cpu_rd_valid,
  output logic [7:0]  cpu_rd_data,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_DONE = 2'd2;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [21:0]  fifo_mem_q [FIFO_DEPTH];
  logic [21:0]  fifo_mem_d [FIFO_DEPTH];
  logic         wr_ready_q, wr_ready_d;
  logic [1:0]   rd_state_q, rd_state_d;
  logic [13:0]  rd_addr_q, rd_addr_d;
  logic [7:0]   rd_data_q, rd_data_d;

  logic         free_slot;
  logic         fifo_empty;
  logic         full_next;
  logic         push;
  logic         pop;
  logic         rd_grant;
  logic [21:0]  fifo_head;

  // Decided from this cycle's inputs only; nothing about the slot pattern is stored.
  assign free_slot  = ~active | (slot_phase == 3'd3) | (slot_phase == 3'd0);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

  // wr_ready_q is already low at full, so a pop in the same cycle cannot
  // open a slot for a push until the next cycle.
  assign push     = rst_n & cpu_wr_valid & wr_ready_q;
  assign pop      = rst_n & free_slot & ~fifo_empty;
  // The FIFO must be empty, so the read sees every write queued before it,
  // including writes pushed while it was waiting.
  assign rd_grant = rst_n & free_slot & fifo_empty & (rd_state_q == RD_WAIT);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q[AW-1:0]] = {cpu_wr_addr, cpu_wr_data};
    end
    // The FIFO is full when the pointer MSBs differ and the index bits match.
    full_next  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    wr_ready_d = ~full_next;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (cpu_rd_req) begin
          rd_addr_d  = cpu_rd_addr;
          rd_state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_grant) begin
          rd_data_d  = vram_rdata;
          rd_state_d = RD_DONE;
        end
      end
      RD_DONE: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ready_q <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ready_q <= wr_ready_d;
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Busy and valid are gated by rst_n so they show idle values while reset is held.
  assign cpu_wr_ready = wr_ready_q;
  assign cpu_rd_busy  = rst_n & (rd_state_q != RD_IDLE);
  assign cpu_rd_valid = rst_n & (rd_state_q == RD_DONE);
  assign cpu_rd_data  = rd_data_q;

  // The fetcher path stays purely combinational. CPU traffic only replaces it in free cycles.
  always_comb begin
    vram_addr  = bg_vram_addr;
    vram_we    = 1'b0;
    vram_wdata = fifo_head[7:0];
    if (rst_n && free_slot) begin
      if (!fifo_empty) begin
        vram_addr = fifo_head[21:8];
        vram_we   = 1'b1;
      end else if (rd_state_q == RD_WAIT) begin
        vram_addr = rd_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
module tb_vdp_vram_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        active;
  logic [2:0]  slot_phase;
  logic [13:0] bg_vram_addr;
  logic        cpu_wr_valid;
  logic [13:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_ready;
  logic        cpu_rd_req;
  logic [13:0] cpu_rd_addr;
  logic        cpu_rd_busy;
  logic        cpu_rd_valid;
  logic [7:0]  cpu_rd_data;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  always #5 clk = ~clk;

  vdp_vram_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .active       (active),
    .slot_phase   (slot_phase),
    .bg_vram_addr (bg_vram_addr),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_rd_req   (cpu_rd_req),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_rd_busy  (cpu_rd_busy),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_rd_data  (cpu_rd_data),
    .vram_addr    (vram_addr),
    .vram_we      (vram_we),
    .vram_wdata   (vram_wdata),
    .vram_rdata   (vram_rdata)
  );

  // VRAM macro: locations never written return a fixed address-derived pattern.
  function automatic logic [7:0] init_val(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  bit [7:0] vmem    [16384];
  bit       vmem_wr [16384];

  assign vram_rdata = vmem_wr[vram_addr] ? vmem[vram_addr] : init_val(vram_addr);

  always @(posedge clk) begin
    if (vram_we) begin
      vmem[vram_addr]    <= vram_wdata;
      vmem_wr[vram_addr] <= 1'b1;
    end
  end

  // Reference model: a queue of pending writes, one outstanding read, and
  // the memory contents that the model expects.
  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         mq[$];
  bit          m_ready;
  bit          m_wait;
  bit          m_done;
  logic [13:0] m_rd_addr;
  logic [7:0]  m_rd_data;
  bit [7:0]    ref_mem [16384];
  bit          ref_wr  [16384];

  bit acc_wr, acc_rd, obs_valid, obs_we;
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [7:0] ref_read(input logic [13:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the DUT against the model at the falling edge, advance
  // the model, then move the inputs to the next cycle just after the rising edge.
  task automatic tick();
    bit          free, exp_we, pop, grant;
    logic [13:0] exp_addr;
    logic [7:0]  exp_wdata;
    @(negedge clk);
    free      = !active || slot_phase == 3'd3 || slot_phase == 3'd0;
    exp_we    = 1'b0;
    exp_addr  = bg_vram_addr;
    exp_wdata = 8'h00;
    if (rst_n && free) begin
      if (mq.size() > 0) begin
        exp_we    = 1'b1;
        exp_addr  = mq[0].a;
        exp_wdata = mq[0].d;
      end else if (m_wait) begin
        exp_addr = m_rd_addr;
      end
    end
    check("vram_we",   32'(vram_we),      32'(exp_we));
    check("vram_addr", 32'(vram_addr),    32'(exp_addr));
    if (exp_we) check("vram_wdata", 32'(vram_wdata), 32'(exp_wdata));
    check("wr_ready",  32'(cpu_wr_ready), 32'(m_ready));
    check("rd_busy",   32'(cpu_rd_busy),  32'(rst_n && (m_wait || m_done)));
    check("rd_valid",  32'(cpu_rd_valid), 32'(rst_n && m_done));
    check("rd_data",   32'(cpu_rd_data),  32'(m_rd_data));
    obs_valid = cpu_rd_valid;
    obs_we    = vram_we;
    acc_wr = rst_n && cpu_wr_valid && m_ready;
    acc_rd = rst_n && cpu_rd_req && !m_wait && !m_done;
    if (!rst_n) begin
      mq.delete();
      m_wait    = 1'b0;
      m_done    = 1'b0;
      m_rd_data = 8'h00;
      m_ready   = 1'b0;
    end else begin
      pop   = free && mq.size() > 0;
      grant = free && mq.size() == 0 && m_wait;
      if (grant) m_rd_data = ref_read(m_rd_addr);
      if (pop) begin
        ref_mem[mq[0].a] = mq[0].d;
        ref_wr[mq[0].a]  = 1'b1;
        void'(mq.pop_front());
      end
      m_done = grant;
      m_wait = acc_rd ? 1'b1 : (m_wait && !grant);
      if (acc_rd) m_rd_addr = cpu_rd_addr;
      if (acc_wr) mq.push_back('{cpu_wr_addr, cpu_wr_data});
      m_ready = mq.size() < DEPTH;
    end
    @(posedge clk);
    #1;
    slot_phase   = slot_phase + 3'd1;
    bg_vram_addr = 14'($urandom);
  endtask

  task automatic push_write(input logic [13:0] a, input logic [7:0] d);
    int i = 0;
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = a;
    cpu_wr_data  = d;
    do begin
      tick();
      i++;
    end while (!acc_wr && i < 40);
    cpu_wr_valid = 1'b0;
    check("wr_accept", 32'(acc_wr), 32'd1);
  endtask

  task automatic request_read(input logic [13:0] a);
    int i = 0;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = a;
    do begin
      tick();
      i++;
    end while (!acc_rd && i < 40);
    cpu_rd_req = 1'b0;
    check("rd_accept", 32'(acc_rd), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!obs_valid && lat < 60);
    check("rd_valid_seen", 32'(obs_valid), 32'd1);
  endtask

  task automatic drain();
    int i = 0;
    while ((mq.size() > 0 || m_wait || m_done) && i < 100) begin
      tick();
      i++;
    end
    check("drain", 32'(mq.size()), 32'd0);
  endtask

  task automatic align(input logic [2:0] p);
    for (int i = 0; i < 8 && slot_phase != p; i++) tick();
  endtask

  initial begin
    int lat, idx, drop_at, we_cnt, val_cnt;
    logic [5:0] we_hist;

    rst_n = 1'b0; active = 1'b0; slot_phase = 3'd0; bg_vram_addr = 14'h0123;
    cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_rd_req = 1'b0; cpu_rd_addr = '0;
    m_ready = 1'b0; m_wait = 1'b0; m_done = 1'b0; m_rd_addr = '0; m_rd_data = '0;

    // Reset release
    repeat (3) tick();
    check("rst_ready_low", 32'(cpu_wr_ready), 32'd0);
    check("rst_rd_data",   32'(cpu_rd_data),  32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", 32'(cpu_wr_ready), 32'd1);

    // Slot protection in active display
    active = 1'b1;
    for (int i = 0; i < 4; i++) push_write(14'h0100 + 14'(i), 8'hA0 + 8'(i));
    drain();
    for (int i = 0; i < 4; i++)
      check("slot_wr_land", 32'(vmem[14'h0100 + 14'(i)]), 32'(8'hA0 + 8'(i)));

    // FIFO full with a burst of 6 writes, starting right after a free phase
    align(3'd4);
    idx = 0;
    drop_at = -1;
    cpu_wr_valid = 1'b1;
    for (int i = 0; i < 60 && idx < 6; i++) begin
      cpu_wr_addr = 14'h0200 + 14'(idx);
      cpu_wr_data = 8'hB0 + 8'(idx);
      tick();
      if (acc_wr) idx++;
      if (!cpu_wr_ready && drop_at < 0) drop_at = idx;
    end
    cpu_wr_valid = 1'b0;
    check("full_after_4", 32'(drop_at), 32'd4);
    drain();
    for (int i = 0; i < 6; i++)
      check("burst_wr_land", 32'(vmem[14'h0200 + 14'(i)]), 32'(8'hB0 + 8'(i)));

    // Read after write to the same address
    push_write(14'h2000, 8'h5A);
    request_read(14'h2000);
    wait_valid(lat);
    check("raw_data", 32'(cpu_rd_data), 32'h5A);
    tick();
    check("raw_single_pulse", 32'(obs_valid), 32'd0);

    // Blanking throughput
    active = 1'b0;
    drain();
    push_write(14'h3FFF, 8'hC3);
    drain();
    request_read(14'h3FFF);
    wait_valid(lat);
    check("blank_rd_latency", 32'(lat), 32'd2);
    check("blank_rd_data", 32'(cpu_rd_data), 32'hC3);
    we_hist = '0;
    for (int i = 0; i < 6; i++) begin
      cpu_wr_valid = (i < 4);
      cpu_wr_addr  = 14'h0300 + 14'(i);
      cpu_wr_data  = 8'hD0 + 8'(i);
      tick();
      we_hist[i] = obs_we;
    end
    cpu_wr_valid = 1'b0;
    check("blank_wr_pattern", 32'(we_hist), 32'(6'b011110));

    // Reset in the middle of queued writes and a waiting read
    active = 1'b1;
    align(3'd4);
    for (int i = 0; i < 3; i++) push_write(14'h0400 + 14'(i), 8'hE0 + 8'(i));
    request_read(14'h0401);
    tick();
    check("mid_busy_before", 32'(cpu_rd_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_busy_after", 32'(cpu_rd_busy), 32'd0);
    active = 1'b0;
    we_cnt = 0;
    val_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      we_cnt  += int'(obs_we);
      val_cnt += int'(obs_valid);
    end
    check("mid_no_we", 32'(we_cnt), 32'd0);
    check("mid_no_valid", 32'(val_cnt), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) active = ~active;
      if ($urandom_range(0, 99) < 2) slot_phase = 3'($urandom);
      rst_n        = ($urandom_range(0, 199) != 0);
      cpu_wr_valid = $urandom_range(0, 1) == 1;
      cpu_wr_addr  = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 15));
      cpu_wr_data  = 8'($urandom);
      cpu_rd_req   = $urandom_range(0, 9) < 3;
      cpu_rd_addr  = 14'($urandom_range(0, 15));
      tick();
    end
    rst_n = 1'b1;
    cpu_wr_valid = 1'b0;
    cpu_rd_req = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
